// File: rtl/piano_pkg.sv
// Shared note table and key-index definitions for the piano / tone-generator family.
// HALF_US holds the half-period in microseconds of each chromatic note from C3 upward.
package piano_pkg;

   localparam int NOTE_COUNT = 36;
   localparam int KEY_IDX_W  = 6;

   localparam int unsigned HALF_US [NOTE_COUNT] = '{
      32'd3822, 32'd3608, 32'd3405, 32'd3214, 32'd3034, 32'd2864,
      32'd2703, 32'd2551, 32'd2408, 32'd2273, 32'd2145, 32'd2025,
      32'd1911, 32'd1804, 32'd1703, 32'd1607, 32'd1517, 32'd1432,
      32'd1351, 32'd1276, 32'd1204, 32'd1136, 32'd1073, 32'd1012,
      32'd956,  32'd902,  32'd851,  32'd804,  32'd758,  32'd716,
      32'd676,  32'd638,  32'd602,  32'd568,  32'd536,  32'd506
   };

   // Out-of-table indices fall back to the lowest note so the counter stays bounded.
   function automatic int unsigned half_us_of(input logic [KEY_IDX_W-1:0] key);
      if (key < KEY_IDX_W'(NOTE_COUNT)) begin
         return HALF_US[key];
      end else begin
         return HALF_US[0];
      end
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises a bank of raw switches and debounces them on a shared sample tick.
// A level is accepted once two consecutive tick samples agree.
module key_debouncer #(
   parameter int WIDTH      = 36,
   parameter int DEB_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int TICK_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic [WIDTH-1:0]  sync1_r;
   logic [WIDTH-1:0]  sync2_r;
   logic [WIDTH-1:0]  sample_r;
   logic [WIDTH-1:0]  db_r;
   logic [TICK_W-1:0] tick_cnt_r;
   logic              tick_s;
   logic [WIDTH-1:0]  stable_s;

   assign tick_s   = (tick_cnt_r == TICK_W'(DEB_CYCLES - 1));
   assign stable_s = ~(sync2_r ^ sample_r);

   // Synchroniser, tick counter and per-key stability compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r    <= '0;
         sync2_r    <= '0;
         sample_r   <= '0;
         db_r       <= '0;
         tick_cnt_r <= '0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         if (tick_s) begin
            tick_cnt_r <= '0;
            sample_r   <= sync2_r;
            db_r       <= (db_r & ~stable_s) | (sync2_r & stable_s);
         end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
         end
      end
   end

   assign dout = db_r;

endmodule

// File: rtl/poly_tone_gen.sv
// Polyphonic square-wave tone generator: debounced keys are allocated to a small
// pool of channels, lowest free key to lowest free channel, one assignment per cycle.
module poly_tone_gen
   import piano_pkg::*;
#(
   parameter int NUM_KEYS   = 36,
   parameter int NUM_CH     = 6,
   parameter int CLK_MHZ    = 50,
   parameter int CNT_W      = 21,
   parameter int DEB_CYCLES = 50000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_KEYS-1:0]         switches,
   output logic [NUM_CH-1:0]           speaker,
   output logic [NUM_CH-1:0]           ch_valid,
   output logic [NUM_CH*KEY_IDX_W-1:0] ch_key,
   output logic [NUM_KEYS-1:0]         keys_db
);

   if (NUM_KEYS > NOTE_COUNT) begin : g_key_range_check
      $error("poly_tone_gen: NUM_KEYS exceeds the note table length");
   end

   logic [NUM_KEYS-1:0]  keys_db_s;
   logic [NUM_KEYS-1:0]  held_s;
   logic [NUM_KEYS-1:0]  cand_s;
   logic                 pend_found_s;
   logic [KEY_IDX_W-1:0] pend_key_s;
   logic [NUM_CH-1:0]    ch_valid_r;
   logic [NUM_CH-1:0]    ch_valid_nxt_s;
   logic [NUM_CH-1:0]    key_db_at_s;
   logic [NUM_CH-1:0]    release_s;
   logic [NUM_CH-1:0]    free_oh_s;
   logic [NUM_CH-1:0]    assign_oh_s;
   logic [KEY_IDX_W-1:0] ch_key_r     [NUM_CH];
   logic [KEY_IDX_W-1:0] ch_key_nxt_s [NUM_CH];

   key_debouncer #(
      .WIDTH      (NUM_KEYS),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_debouncer (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (switches),
      .dout  (keys_db_s)
   );

   // Which keys are already voiced, and which voiced keys have been let go.
   always_comb begin
      held_s      = '0;
      key_db_at_s = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            held_s[k]       = held_s[k] | (ch_valid_r[ch] & (ch_key_r[ch] == KEY_IDX_W'(k)));
            key_db_at_s[ch] = key_db_at_s[ch] | (keys_db_s[k] & (ch_key_r[ch] == KEY_IDX_W'(k)));
         end
      end
      release_s = ch_valid_r & ~key_db_at_s;
      cand_s    = keys_db_s & ~held_s;
   end

   // Lowest pending key; ~v & (v+1) isolates the lowest channel invalid at cycle start.
   always_comb begin
      pend_key_s = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         pend_key_s = cand_s[k] ? KEY_IDX_W'(k) : pend_key_s;
      end
      pend_found_s = |cand_s;
      free_oh_s    = ~ch_valid_r & (ch_valid_r + NUM_CH'(1));
      assign_oh_s  = pend_found_s ? free_oh_s : '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         ch_valid_nxt_s[ch] = (ch_valid_r[ch] & ~release_s[ch]) | assign_oh_s[ch];
         ch_key_nxt_s[ch]   = assign_oh_s[ch] ? pend_key_s : ch_key_r[ch];
      end
   end

   // Channel ownership registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_valid_r <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            ch_key_r[ch] <= '0;
         end
      end else begin
         ch_valid_r <= ch_valid_nxt_s;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            ch_key_r[ch] <= ch_key_nxt_s[ch];
         end
      end
   end

   assign ch_valid = ch_valid_r;
   assign keys_db  = keys_db_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_nxt_s;
      logic [CNT_W-1:0] tc_m1_s;
      logic             wave_r;
      logic             wave_nxt_s;
      logic             spk_r;

      assign tc_m1_s = CNT_W'(32'(CLK_MHZ) * half_us_of(ch_key_r[i]) - 32'd1);

      // Half-period counter; a fresh assignment restarts the tone at phase zero.
      always_comb begin
         cnt_nxt_s  = cnt_r;
         wave_nxt_s = wave_r;
         if (assign_oh_s[i]) begin
            cnt_nxt_s  = '0;
            wave_nxt_s = 1'b0;
         end else if (ch_valid_r[i]) begin
            if (cnt_r == tc_m1_s) begin
               cnt_nxt_s  = '0;
               wave_nxt_s = ~wave_r;
            end else begin
               cnt_nxt_s  = cnt_r + CNT_W'(1);
            end
         end else begin
            cnt_nxt_s  = cnt_r;
            wave_nxt_s = wave_r;
         end
      end

      // Wave state and gated speaker output.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_r  <= '0;
            wave_r <= 1'b0;
            spk_r  <= 1'b0;
         end else begin
            cnt_r  <= cnt_nxt_s;
            wave_r <= wave_nxt_s;
            spk_r  <= wave_nxt_s & ch_valid_nxt_s[i];
         end
      end

      assign speaker[i] = spk_r;
      assign ch_key[i*KEY_IDX_W +: KEY_IDX_W] = ch_key_r[i];
   end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Directed bench for poly_tone_gen with a 1 MHz note table, 4-cycle debounce tick
// and two channels; expected timings are hand-derived from the note table.
module tb_poly_tone_gen;

   localparam int NK = 36;
   localparam int NC = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] switches = '0;
   logic [NC-1:0] speaker;
   logic [NC-1:0] ch_valid;
   logic [NC*6-1:0] ch_key;
   logic [NK-1:0] keys_db;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int a1_cyc = 0;

   poly_tone_gen #(
      .NUM_KEYS   (NK),
      .NUM_CH     (NC),
      .CLK_MHZ    (1),
      .CNT_W      (21),
      .DEB_CYCLES (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .switches (switches),
      .speaker  (speaker),
      .ch_valid (ch_valid),
      .ch_key   (ch_key),
      .keys_db  (keys_db)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic wait_db(input int k, input logic lvl, input int max_cyc, output int waited);
      waited = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (keys_db[k] === lvl) begin
            waited = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      switches = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({speaker, ch_valid, ch_key, keys_db} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got spk=%b val=%b key=%h db=%h required all 0", speaker, ch_valid, ch_key, keys_db);
      end
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if ({speaker, ch_valid, keys_db} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset got spk=%b val=%b db=%h required all 0", speaker, ch_valid, keys_db);
      end
   endtask

   task automatic test_single_key();
      int w;
      switches[0] = 1'b1;
      wait_db(0, 1'b1, 11, w);
      checks++;
      if (w < 0) begin
         errors++;
         $display("FAIL single_db_rise got timeout required keys_db[0]=1 within 11 cycles");
      end
      checks++;
      if (ch_valid !== 2'b00) begin
         errors++;
         $display("FAIL single_not_yet_assigned got %b required 00", ch_valid);
      end
      @(negedge clk);
      checks++;
      if (ch_valid !== 2'b01 || ch_key[5:0] !== 6'd0 || speaker !== 2'b00) begin
         errors++;
         $display("FAIL single_assign got val=%b key0=%0d spk=%b required 01 0 00", ch_valid, ch_key[5:0], speaker);
      end
      repeat (3821) @(negedge clk);
      checks++;
      if (speaker[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_before_rise got %b required 0", speaker[0]);
      end
      @(negedge clk);
      checks++;
      if (speaker[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_rise_3822 got %b required 1", speaker[0]);
      end
      repeat (3821) @(negedge clk);
      checks++;
      if (speaker[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_before_fall got %b required 1", speaker[0]);
      end
      @(negedge clk);
      checks++;
      if (speaker[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_fall_7644 got %b required 0", speaker[0]);
      end
   endtask

   task automatic test_reset_mid_tone();
      int w;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (speaker[0] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL midtone_speaker_high got timeout required speaker[0]=1");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({speaker, ch_valid, ch_key, keys_db} !== '0) begin
         errors++;
         $display("FAIL midtone_async_reset got spk=%b val=%b key=%h db=%h required all 0", speaker, ch_valid, ch_key, keys_db);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_db(0, 1'b1, 11, w);
      checks++;
      if (w < 0) begin
         errors++;
         $display("FAIL midtone_redebounce got timeout required keys_db[0]=1");
      end
      @(negedge clk);
      checks++;
      if (ch_valid !== 2'b01 || ch_key[5:0] !== 6'd0 || speaker !== 2'b00) begin
         errors++;
         $display("FAIL midtone_reassign got val=%b key0=%0d spk=%b required 01 0 00", ch_valid, ch_key[5:0], speaker);
      end
      switches[0] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (ch_valid === 2'b00) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || speaker !== 2'b00) begin
         errors++;
         $display("FAIL midtone_release got val=%b spk=%b required 00 00", ch_valid, speaker);
      end
   endtask

   task automatic test_debounce_reject();
      int bad;
      bad = 0;
      @(negedge clk);
      switches[5] = 1'b1;
      repeat (2) @(negedge clk);
      switches[5] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (keys_db !== '0 || ch_valid !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL debounce_reject got %0d bad cycles db=%h val=%b required 0", bad, keys_db, ch_valid);
      end
   endtask

   task automatic test_simultaneous();
      int w;
      int rise0;
      int rise1;
      logic [NK-1:0] exp_db;
      exp_db = '0;
      exp_db[12] = 1'b1;
      exp_db[24] = 1'b1;
      exp_db[35] = 1'b1;
      rise0 = -1;
      rise1 = -1;
      switches[12] = 1'b1;
      switches[24] = 1'b1;
      switches[35] = 1'b1;
      wait_db(12, 1'b1, 11, w);
      checks++;
      if (w < 0 || keys_db !== exp_db || ch_valid !== 2'b00) begin
         errors++;
         $display("FAIL simul_db got db=%h val=%b required %h 00", keys_db, ch_valid, exp_db);
      end
      @(negedge clk);
      checks++;
      if (ch_valid !== 2'b01 || ch_key[5:0] !== 6'd12) begin
         errors++;
         $display("FAIL simul_ch0 got val=%b key0=%0d required 01 12", ch_valid, ch_key[5:0]);
      end
      @(negedge clk);
      a1_cyc = cyc;
      checks++;
      if (ch_valid !== 2'b11 || ch_key !== {6'd24, 6'd12}) begin
         errors++;
         $display("FAIL simul_ch1 got val=%b key1=%0d key0=%0d required 11 24 12", ch_valid, ch_key[11:6], ch_key[5:0]);
      end
      for (int i = 1; i <= 2000; i++) begin
         @(negedge clk);
         if (speaker[0] === 1'b1 && rise0 < 0) rise0 = cyc - a1_cyc;
         if (speaker[1] === 1'b1 && rise1 < 0) rise1 = cyc - a1_cyc;
      end
      checks++;
      if (rise1 != 956) begin
         errors++;
         $display("FAIL simul_half_ch1 got %0d required 956", rise1);
      end
      checks++;
      if (rise0 != 1910) begin
         errors++;
         $display("FAIL simul_half_ch0 got %0d required 1910", rise0);
      end
      checks++;
      if (ch_valid !== 2'b11 || ch_key !== {6'd24, 6'd12}) begin
         errors++;
         $display("FAIL simul_key35_waits got val=%b key=%h required 11 %h", ch_valid, ch_key, {6'd24, 6'd12});
      end
   endtask

   task automatic test_release_realloc();
      int w;
      int a2;
      int rise0;
      int toggles;
      int misaligned;
      logic prev1;
      rise0 = -1;
      toggles = 0;
      misaligned = 0;
      switches[12] = 1'b0;
      wait_db(12, 1'b0, 11, w);
      checks++;
      if (w < 0 || ch_valid !== 2'b11) begin
         errors++;
         $display("FAIL realloc_db_fall got w=%0d val=%b required fall with val 11", w, ch_valid);
      end
      @(negedge clk);
      checks++;
      if (ch_valid !== 2'b10 || speaker[0] !== 1'b0 || ch_key[5:0] !== 6'd12) begin
         errors++;
         $display("FAIL realloc_release got val=%b spk0=%b key0=%0d required 10 0 12", ch_valid, speaker[0], ch_key[5:0]);
      end
      @(negedge clk);
      a2 = cyc;
      checks++;
      if (ch_valid !== 2'b11 || ch_key !== {6'd24, 6'd35}) begin
         errors++;
         $display("FAIL realloc_key35 got val=%b key1=%0d key0=%0d required 11 24 35", ch_valid, ch_key[11:6], ch_key[5:0]);
      end
      prev1 = speaker[1];
      for (int i = 1; i <= 1200; i++) begin
         @(negedge clk);
         if (speaker[0] === 1'b1 && rise0 < 0) rise0 = cyc - a2;
         if (speaker[1] !== prev1) begin
            toggles++;
            if (((cyc - a1_cyc) % 956) != 0) misaligned++;
         end
         prev1 = speaker[1];
      end
      checks++;
      if (rise0 != 506) begin
         errors++;
         $display("FAIL realloc_half_506 got %0d required 506", rise0);
      end
      checks++;
      if (toggles < 1 || misaligned != 0) begin
         errors++;
         $display("FAIL realloc_ch1_phase got toggles=%0d misaligned=%0d required >=1 and 0", toggles, misaligned);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      switches[3] = 1'b1;
      wait_db(3, 1'b1, 11, w);
      repeat (3) @(negedge clk);
      checks++;
      if (w < 0 || ch_valid !== 2'b11 || ch_key !== {6'd24, 6'd35}) begin
         errors++;
         $display("FAIL b2b_pending_waits got w=%0d val=%b key=%h required 11 %h", w, ch_valid, ch_key, {6'd24, 6'd35});
      end
      switches[24] = 1'b0;
      wait_db(24, 1'b0, 11, w);
      checks++;
      if (w < 0 || ch_valid !== 2'b11) begin
         errors++;
         $display("FAIL b2b_db_fall got w=%0d val=%b required fall with val 11", w, ch_valid);
      end
      @(negedge clk);
      checks++;
      if (ch_valid !== 2'b01 || speaker[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_release_cycle got val=%b spk1=%b required 01 0", ch_valid, speaker[1]);
      end
      @(negedge clk);
      checks++;
      if (ch_valid !== 2'b11 || ch_key !== {6'd3, 6'd35} || speaker[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_assign_next got val=%b key1=%0d key0=%0d spk1=%b required 11 3 35 0", ch_valid, ch_key[11:6], ch_key[5:0], speaker[1]);
      end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_reset_mid_tone();
      test_debounce_reject();
      test_simultaneous();
      test_release_realloc();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/poly_tone_gen.md
Name: poly_tone_gen

Overview:
- Polyphonic square-wave tone generator and successor to the fixed 36-key, one-speaker-per-note piano.
- Debounces NUM_KEYS key switches and dynamically allocates pressed keys to NUM_CH shared output channels. Each channel is a programmable-period square-wave generator.
- Replaces hard-wired per-note outputs and OR-overloaded pins with deterministic voice allocation, so the output pin count is independent of key count.

Parameters:
- NUM_KEYS, 36, number of key inputs; key k plays note k of the shared half-period table (C3 upward, chromatic).
- NUM_CH, 6, number of output channels (voices).
- CLK_MHZ, 50, system clock frequency in MHz; the half-period in cycles is CLK_MHZ*HALF_US[k].
- CNT_W, 21, width of the period counter; must hold CLK_MHZ*HALF_US[0]-1.
- DEB_CYCLES, 50000, debounce sample interval in clock cycles (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- switches  in  NUM_KEYS  raw key inputs, asynchronous, active-high.
- speaker  out  NUM_CH  square-wave output per channel; 0 when the channel is idle.
- ch_valid  out  NUM_CH  channel currently assigned to a key.
- ch_key  out  NUM_CH*6  key index of each channel, packed as channel i at bits [6i+5:6i]; holds its last value when the channel is idle.
- keys_db  out  NUM_KEYS  debounced key state.

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0: speaker, ch_valid, ch_key, keys_db, synchroniser flops, tick counter, period counters, wave flops.
- Sync: each switch passes through a 2-FF synchroniser.
- Debounce tick: a shared counter counts 0..DEB_CYCLES-1. On wrap (tick), per key: sample <= sync; if sync == previous sample, then keys_db <= sync.
  - A level change therefore reaches keys_db at the second tick after it appears on sync.
  - A glitch shorter than one tick interval never reaches keys_db.
- Release: every cycle, each valid channel whose keys_db[ch_key] is 0 clears ch_valid. All such channels are released in the same cycle. speaker for a released channel goes 0 the next cycle.
- Assignment: at most one per cycle.
  - Selects the lowest-index key with keys_db=1 that is not held by any valid channel.
  - Places it on the lowest-index channel that is invalid at the start of the cycle.
  - A channel being released in the current cycle is not available until the next cycle.
- No free channel: the pending key waits; no voice stealing. It is assigned when a channel frees, in lowest-key-first order.
- On assignment: ch_valid <= 1, ch_key <= k, period counter <= 0, wave <= 0.
- Tone generation, per valid channel:
  - The counter counts 0..TC-1 with TC = CLK_MHZ*HALF_US[ch_key]. On reaching TC-1, counter <= 0 and wave toggles.
  - Full period = 2*TC cycles.
- speaker[i] = wave[i] & ch_valid[i], registered.
- Key index >= table length is illegal; the design asserts NUM_KEYS <= 36 at elaboration.
- A key released and re-pressed between two ticks produces no keys_db change and therefore no re-allocation.

Decomposition:
- Package piano_pkg:
  - NOTE_COUNT = 36.
  - HALF_US[0:35] = 3822, 3608, 3405, 3214, 3034, 2864, 2703, 2551, 2408, 2273, 2145, 2025, 1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012, 956, 902, 851, 804, 758, 716, 676, 638, 602, 568, 536, 506.
  - KEY_IDX_W = 6.
- Sub-module key_debouncer: parametrised by width and DEB_CYCLES. Contains the synchroniser, tick counter and stability compare; used once here.
- The allocator and channel generators stay in poly_tone_gen; the channel generator is a generate loop.

Test Plan (CLK_MHZ=1, DEB_CYCLES=4, NUM_CH=2 unless noted):
- Reset mid-tone: hold key 0 until speaker[0] toggles, then assert rst_n=0 -> all outputs are 0 asynchronously; after release, key 0 is re-debounced and reassigned with speaker starting at 0.
- Single key: press switches[0] -> keys_db[0] rises within 2 sync cycles + 2 ticks (<= 11 cycles); the next cycle ch_valid=01 and ch_key[0]=0; speaker[0] toggles every 3822 cycles (period 7644).
- Debounce reject: a 2-cycle pulse on switches[5] -> keys_db stays 0, no channel is assigned.
- Simultaneous press of keys 12, 24, 35 -> key 12 goes to ch0 in cycle n and key 24 to ch1 in cycle n+1; key 35 waits. Half-periods are 1911 and 956 cycles.
- Release and reallocation (continuing the previous case): release key 12 -> ch0 invalid one cycle after keys_db falls, then ch0 takes key 35 (half-period 506) in the following cycle; ch1 is undisturbed with no phase glitch.
- Same-cycle release and pending key: with both channels full and a pending key, release ch1's key -> ch1 is not reassigned in the release cycle but is assigned to the pending key exactly one cycle later.
